// File: rtl/logic_seq_pkg.sv
// Shared definitions for the logic sequencer: opcodes, FSM states and
// INSTR field positions. Imported by the sequencer top and its register file.
// The debug read path stays combinational; everything else is registered.
package logic_seq_pkg;

  localparam logic [1:0] OPC_OR  = 2'b00;
  localparam logic [1:0] OPC_AND = 2'b01;
  localparam logic [1:0] OPC_LDI = 2'b10;
  localparam logic [1:0] OPC_TST = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  // Lowest bit of each 2-bit INSTR field
  localparam int INSTR_OPC_LSB  = 6;
  localparam int INSTR_DST_LSB  = 4;
  localparam int INSTR_SRCA_LSB = 2;
  localparam int INSTR_SRCB_LSB = 0;

  function automatic logic [1:0] instr_field(input logic [7:0] instr, input int lsb);
    return instr[lsb +: 2];
  endfunction

endpackage

// File: rtl/logic_regfile.sv
// Register file: NREGS x WIDTH, one synchronous write port, two operand
// read ports and one debug read port, all reads combinational.
// Synchronous active-high reset clears every entry to 0.
module logic_regfile #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_we,
  input  logic [$clog2(NREGS)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(NREGS)-1:0] i_raddr_a,
  output logic [WIDTH-1:0]         o_rdata_a,
  input  logic [$clog2(NREGS)-1:0] i_raddr_b,
  output logic [WIDTH-1:0]         o_rdata_b,
  input  logic [$clog2(NREGS)-1:0] i_raddr_d,
  output logic [WIDTH-1:0]         o_rdata_d
);

  logic [WIDTH-1:0] r_regs [NREGS];

  // Storage update: reset clears all entries, otherwise a single write per cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_regs[i_raddr_a];
  assign o_rdata_b = r_regs[i_raddr_b];
  assign o_rdata_d = r_regs[i_raddr_d];

endmodule

// File: rtl/logic_sequencer.sv
// Operand sequencer for an external 8-bit AND/OR unit: accepts one
// instruction per two cycles, presents registered operands, and writes the
// unit's result back into a 4-entry register file one cycle later.
module logic_sequencer
  import logic_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [7:0]       i_instr,
  input  logic [WIDTH-1:0] i_imm,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic             o_alu_op,
  input  logic [WIDTH-1:0] i_alu_y,
  output logic [WIDTH-1:0] o_result,
  output logic             o_done,
  output logic             o_z,
  input  logic [1:0]       i_reg_sel,
  output logic [WIDTH-1:0] o_reg_data
);

  state_t           r_state;
  logic [1:0]       r_opc;
  logic [1:0]       r_dst;
  logic [WIDTH-1:0] r_imm;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic             r_alu_op;
  logic [WIDTH-1:0] r_result;
  logic             r_done;
  logic             r_z;

  logic [1:0]       w_opc;
  logic [1:0]       w_dst;
  logic [1:0]       w_srca;
  logic [1:0]       w_srcb;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;
  logic             w_accept;
  logic             w_we;
  logic [WIDTH-1:0] w_wdata;

  assign w_opc  = instr_field(i_instr, INSTR_OPC_LSB);
  assign w_dst  = instr_field(i_instr, INSTR_DST_LSB);
  assign w_srca = instr_field(i_instr, INSTR_SRCA_LSB);
  assign w_srcb = instr_field(i_instr, INSTR_SRCB_LSB);

  assign o_in_ready = (r_state == ST_IDLE) && !i_rst;
  assign w_accept   = i_in_valid && o_in_ready;

  // Write-back happens in the EXEC cycle; TST only updates flags and RESULT.
  // LDI writes the captured immediate, OR/AND write the unit's output.
  assign w_we    = (r_state == ST_EXEC) && (r_opc != OPC_TST);
  assign w_wdata = (r_opc == OPC_LDI) ? r_imm : i_alu_y;

  logic_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_we      (w_we),
    .i_waddr   (r_dst),
    .i_wdata   (w_wdata),
    .i_raddr_a (w_srca),
    .o_rdata_a (w_rd_a),
    .i_raddr_b (w_srcb),
    .o_rdata_b (w_rd_b),
    .i_raddr_d (i_reg_sel),
    .o_rdata_d (o_reg_data)
  );

  // Two-state sequencer: capture and present operands on accept, retire next cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_opc    <= OPC_OR;
      r_dst    <= '0;
      r_imm    <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_z      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_opc <= w_opc;
            r_dst <= w_dst;
            r_imm <= i_imm;
            // LDI leaves the unit's operands untouched
            if (w_opc != OPC_LDI) begin
              r_alu_a  <= w_rd_a;
              r_alu_b  <= w_rd_b;
              r_alu_op <= (w_opc == OPC_AND) || (w_opc == OPC_TST);
            end
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (r_opc)
            OPC_OR, OPC_AND, OPC_TST: begin
              r_result <= i_alu_y;
              r_z      <= (i_alu_y == '0);
            end
            default: begin
              r_result <= r_imm;
            end
          endcase
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_alu_a  = r_alu_a;
  assign o_alu_b  = r_alu_b;
  assign o_alu_op = r_alu_op;
  assign o_result = r_result;
  assign o_done   = r_done;
  assign o_z      = r_z;

endmodule

// File: tb/tb_logic_sequencer.sv
// Directed plus randomized bench for logic_sequencer with the logical unit
// modelled externally and an architectural reference model of the register
// file, RESULT, Z and the operands presented to the unit.
module tb_logic_sequencer;
  import logic_seq_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] instr;
  logic [7:0] imm_i;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_op;
  logic [7:0] alu_y;
  logic [7:0] result;
  logic       done;
  logic       z;
  logic [1:0] reg_sel;
  logic [7:0] reg_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_q[$];

  // Reference model state
  logic [7:0] m_regs [4];
  logic [7:0] m_a;
  logic [7:0] m_b;
  logic       m_op;
  logic [7:0] m_result;
  logic       m_z;

  logic_sequencer #(.WIDTH(8), .NREGS(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_instr    (instr),
    .i_imm      (imm_i),
    .o_alu_a    (alu_a),
    .o_alu_b    (alu_b),
    .o_alu_op   (alu_op),
    .i_alu_y    (alu_y),
    .o_result   (result),
    .o_done     (done),
    .o_z        (z),
    .i_reg_sel  (reg_sel),
    .o_reg_data (reg_data)
  );

  // The external logical unit
  assign alu_y = alu_op ? (alu_a & alu_b) : (alu_a | alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) acc_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_a = 8'h00; m_b = 8'h00; m_op = 1'b0; m_result = 8'h00; m_z = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      reg_sel = 2'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), {24'h0, reg_data}, {24'h0, m_regs[i]});
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_alu_a"},  {24'h0, alu_a},  {24'h0, m_a});
    chk({tag, "_alu_b"},  {24'h0, alu_b},  {24'h0, m_b});
    chk({tag, "_alu_op"}, {31'h0, alu_op}, {31'h0, m_op});
    chk({tag, "_result"}, {24'h0, result}, {24'h0, m_result});
    chk({tag, "_z"},      {31'h0, z},      {31'h0, m_z});
  endtask

  // Issue one instruction from an IDLE cycle and follow it to retirement
  task automatic do_instr(input logic [1:0] opc, input logic [1:0] dst,
                          input logic [1:0] sa, input logic [1:0] sb,
                          input logic [7:0] imm, input bit keep_valid);
    logic [7:0] y;
    in_valid = 1'b1;
    instr    = {opc, dst, sa, sb};
    imm_i    = imm;
    #1;
    chk("ready_before_accept", {31'h0, in_ready}, 32'd1);
    @(posedge clk); #1;
    // Busy cycle: scramble inputs, they must be ignored
    if (!keep_valid) in_valid = 1'b0;
    instr = 8'($urandom);
    imm_i = 8'($urandom);
    #1;
    chk("ready_exec", {31'h0, in_ready}, 32'd0);
    chk("done_exec",  {31'h0, done},     32'd0);
    if (opc != OPC_LDI) begin
      m_a  = m_regs[sa];
      m_b  = m_regs[sb];
      m_op = (opc != OPC_OR);
    end
    chk("alu_a_exec",  {24'h0, alu_a},  {24'h0, m_a});
    chk("alu_b_exec",  {24'h0, alu_b},  {24'h0, m_b});
    chk("alu_op_exec", {31'h0, alu_op}, {31'h0, m_op});
    y = m_op ? (m_a & m_b) : (m_a | m_b);
    case (opc)
      OPC_OR, OPC_AND: begin m_regs[dst] = y; m_result = y; m_z = (y == 8'h00); end
      OPC_TST:         begin m_result = y; m_z = (y == 8'h00); end
      default:         begin m_regs[dst] = imm; m_result = imm; end
    endcase
    @(posedge clk); #1;
    chk("done_pulse",   {31'h0, done},     32'd1);
    chk("ready_retire", {31'h0, in_ready}, 32'd1);
    chk("result",       {24'h0, result},   {24'h0, m_result});
    chk("z",            {31'h0, z},        {31'h0, m_z});
    check_regs("wb");
  endtask

  initial begin
    int start;
    rst = 1'b1; in_valid = 1'b0; instr = 8'h00; imm_i = 8'h00; reg_sel = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("ready_in_reset", {31'h0, in_ready}, 32'd0);
    chk("done_in_reset",  {31'h0, done},     32'd0);
    check_outputs("reset");
    check_regs("reset");
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {31'h0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Directed sequence
    do_instr(OPC_LDI, 2'd0, 2'd0, 2'd0, 8'hF0, 1'b0);
    do_instr(OPC_LDI, 2'd1, 2'd0, 2'd0, 8'h3C, 1'b0);
    chk("z_after_ldi", {31'h0, z}, 32'd0);
    do_instr(OPC_OR,  2'd2, 2'd0, 2'd1, 8'h00, 1'b0);
    chk("or_result_fc", {24'h0, result}, 32'hFC);
    do_instr(OPC_AND, 2'd3, 2'd0, 2'd1, 8'h00, 1'b0);
    chk("and_result_30", {24'h0, result}, 32'h30);
    do_instr(OPC_LDI, 2'd1, 2'd0, 2'd0, 8'h0F, 1'b0);
    do_instr(OPC_AND, 2'd1, 2'd0, 2'd1, 8'h00, 1'b0);
    chk("and_dst_srcb_z", {31'h0, z}, 32'd1);
    do_instr(OPC_LDI, 2'd1, 2'd0, 2'd0, 8'h0F, 1'b0);
    do_instr(OPC_TST, 2'd2, 2'd0, 2'd1, 8'h00, 1'b0);
    chk("tst_z", {31'h0, z}, 32'd1);

    // IN_VALID held high across three instructions
    start = acc_q.size();
    do_instr(OPC_OR,  2'd3, 2'd2, 2'd1, 8'h00, 1'b1);
    do_instr(OPC_LDI, 2'd0, 2'd0, 2'd0, 8'h5A, 1'b1);
    do_instr(OPC_AND, 2'd2, 2'd0, 2'd3, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_accepts", 32'(acc_q.size() - start), 32'd3);
    if (acc_q.size() - start == 3) begin
      chk("b2b_gap0", 32'(acc_q[start+1] - acc_q[start]),   32'd2);
      chk("b2b_gap1", 32'(acc_q[start+2] - acc_q[start+1]), 32'd2);
    end

    // Randomized instructions
    for (int n = 0; n < 40; n++) begin
      do_instr(2'($urandom_range(0, 3)), 2'($urandom), 2'($urandom), 2'($urandom),
               8'($urandom), 1'($urandom_range(0, 1)));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_done", {31'h0, done}, 32'd0);
    check_outputs("post_random");

    // Reset during EXEC aborts the instruction
    do_instr(OPC_LDI, 2'd0, 2'd0, 2'd0, 8'h81, 1'b0);
    do_instr(OPC_LDI, 2'd1, 2'd0, 2'd0, 8'h42, 1'b0);
    in_valid = 1'b1;
    instr    = {OPC_OR, 2'd2, 2'd0, 2'd1};
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("ready_rst_exec", {31'h0, in_ready}, 32'd0);
    @(posedge clk); #1;
    model_reset();
    chk("abort_no_done",   {31'h0, done},     32'd0);
    chk("ready_rst_held",  {31'h0, in_ready}, 32'd0);
    check_outputs("abort");
    check_regs("abort");
    @(posedge clk); #1;
    chk("done_rst_held2", {31'h0, done}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_release", {31'h0, in_ready}, 32'd1);
    chk("done_after_release",  {31'h0, done},     32'd0);
    check_regs("released");
    do_instr(OPC_LDI, 2'd3, 2'd0, 2'd0, 8'hA5, 1'b0);
    do_instr(OPC_OR,  2'd0, 2'd3, 2'd1, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
